kernel_buffer_pingpong: RTL and testbench
=========================================

# kernel_buffer_pingpong

Double-buffered kernel weight store for the Conv2d engine. It accepts a stream of individual weights, packs KSIZE×KSIZE taps into one kernel word per input channel, and writes each word into the fill bank of two BRAM banks. The convolution datapath reads packed kernel words from the other bank, so the next layer's weights load while the current layer computes. It replaces the single-bank kernel BRAM datapath, which had no packing, no bank swapping and fixed geometry.

## Interface
- KERNEL_WIDTH, 16, bits per weight
- KSIZE, 3, kernel side; TAPS = KSIZE*KSIZE
- MAX_CH, 256, entries per bank; ADDR_W = clog2(MAX_CH)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle pulse that begins a load
- load_channels  in  ADDR_W+1  channel count, 1..MAX_CH; sampled on load_start
- load_busy  out  1  high from an accepted load_start until the load commits
- s_weight_data  in  KERNEL_WIDTH  one weight
- s_weight_valid  in  1  weight present
- s_weight_ready  out  1  weight accepted when valid && ready
- bank_full  out  2  per-bank "holds a complete kernel set"
- rd_bank_ready  out  1  = bank_full[rd_bank]
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  channel index
- rd_data  out  KERNEL_WIDTH*TAPS  packed kernel word
- rd_valid  out  1  rd_data is valid this cycle
- rd_release  in  1  pulse that marks the read bank consumed and swaps banks

## Operation
- Two banks, each MAX_CH × (KERNEL_WIDTH*TAPS). Bank pointers: wr_bank (fill) and rd_bank (read). Both reset to 0.
- Loader FSM states:
  - IDLE: on load_start with load_channels != 0, latch the count and clear the tap and channel counters. Go to LOAD if bank_full[wr_bank] == 0, otherwise go to WAIT. load_start with count 0 is ignored.
  - WAIT: s_weight_ready = 0. Go to LOAD once bank_full[wr_bank] == 0.
  - LOAD: s_weight_ready = 1. Each accepted weight goes into tap slot tap_cnt, bits [tap_cnt*KW +: KW], so tap 0 is the LSBs and taps arrive row-major.
- On acceptance of tap TAPS-1:
  - Write the packed word (earlier taps plus the incoming weight) to wr_bank at address ch_cnt on the same edge.
  - Reset tap_cnt to 0 and increment ch_cnt.
- If that word is the last channel (ch_cnt == count-1), on the same edge:
  - set bank_full[wr_bank]
  - toggle wr_bank
  - return to IDLE
- load_busy = (state != IDLE). load_start while busy is ignored.
- Read side:
  - rd_en is honoured only when rd_bank_ready. It reads rd_bank at rd_addr.
  - rd_addr is not range-checked. Addresses ≥ the loaded count return stale contents.
- rd_release with rd_bank_ready clears bank_full[rd_bank] and toggles rd_bank. rd_release is ignored when not ready.
- rd_en and rd_release in the same cycle: the read uses the pre-toggle bank, then the release takes effect.
- Commit and release on the same edge touch different banks, so both take effect.
- Reset mid-load aborts the load. The partially written bank is not marked full, and its contents are undefined. Reset clears both bank_full bits.

## Timing
- Reset values: load_busy 0, s_weight_ready 0, bank_full 2'b00, rd_bank_ready 0, rd_valid 0, rd_data 0.
- s_weight_ready is a registered-state decode. It is high in every LOAD cycle, so sustained throughput is one weight per cycle and a full bank takes count*TAPS cycles.
- load_busy rises on the edge after load_start and falls on the commit edge.
- Read latency is 1 cycle: rd_en at edge N gives rd_data and rd_valid = 1 after edge N+1.
- rd_valid falls the cycle after the last rd_en. rd_data holds its value until the next honoured read.
- bank_full and rd_bank_ready reflect a commit on the edge after the final tap is accepted. A read of the committed bank is legal from that cycle.
- After rd_release, a waiting loader enters LOAD one cycle later, and s_weight_ready rises on the following edge.

## Test plan
- Reset, then load_channels=2 with weights 1..18 → bank0 addr0 = taps 1..9 (tap0 = 1 in LSBs), addr1 = 10..18. bank_full=01 after the 18th accepted weight. rd_en addr1 → rd_valid one cycle later with the packed 10..18.
- Ping-pong: load bank0, then start a load of 4 channels → bank1 fills while reads from bank0 continue. rd_release → rd_bank moves to bank1, bank_full=10.
- Back-pressure: with both banks full, load_start → state WAIT and s_weight_ready stays 0 for 20 cycles. rd_release → ready rises 2 cycles later, and the load completes into bank0.
- Same-cycle rd_en and rd_release → data comes from the old bank and rd_bank toggles. A following rd_en while the new bank is not full is ignored (rd_valid 0).
- Reset after 5 weights of a 1-channel load → bank_full=00, load_busy 0. A new load of 1 channel with weights 100..108 reads back exactly 100..108.
- load_start with load_channels=0 → no state change. load_channels=MAX_CH (256) → addr 255 written and the bank commits after 2304 weights.

Source files
------------

// File: rtl/kernel_buffer_pingpong.sv
// Double-buffered kernel weight store: packs TAPS weights per channel into one word and
// fills one bank while the conv datapath reads the other; banks swap on commit/release.
module kernel_buffer_pingpong #(
   parameter int unsigned KERNEL_WIDTH = 16,
   parameter int unsigned KSIZE        = 3,
   parameter int unsigned MAX_CH       = 256,
   localparam int unsigned TAPS        = KSIZE * KSIZE,
   localparam int unsigned ADDR_W      = $clog2(MAX_CH),
   localparam int unsigned WORD_W      = KERNEL_WIDTH * TAPS,
   localparam int unsigned TAP_W       = $clog2(TAPS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_start,
   input  logic [ADDR_W:0]         load_channels,
   output logic                    load_busy,
   input  logic [KERNEL_WIDTH-1:0] s_weight_data,
   input  logic                    s_weight_valid,
   output logic                    s_weight_ready,
   output logic [1:0]              bank_full,
   output logic                    rd_bank_ready,
   input  logic                    rd_en,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [WORD_W-1:0]       rd_data,
   output logic                    rd_valid,
   input  logic                    rd_release
);

   typedef enum logic [1:0] {IDLE, WAIT, LOAD} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W:0]    cnt_q, cnt_d;
   logic [ADDR_W:0]    ch_q, ch_d;
   logic [TAP_W-1:0]   tap_q, tap_d;
   logic [WORD_W-1:0]  pack_q, pack_d;
   logic               wr_bank_q, wr_bank_d;
   logic               rd_bank_q, rd_bank_d;
   logic [1:0]         bank_full_q, bank_full_d;
   logic               rd_valid_q;
   logic [WORD_W-1:0]  rd_data_q;
   logic [WORD_W-1:0]  word_w;
   logic               wr_fire, rd_fire, rel_fire;

   // Both banks live in one array, addressed by {bank, channel}
   logic [WORD_W-1:0]  bank_mem [2*MAX_CH];

   assign load_busy      = (state_q != IDLE);
   assign s_weight_ready = (state_q == LOAD);
   assign bank_full      = bank_full_q;
   assign rd_bank_ready  = bank_full_q[rd_bank_q];
   assign rd_valid       = rd_valid_q;
   assign rd_data        = rd_data_q;
   assign rd_fire        = rd_en && rd_bank_ready;
   assign rel_fire       = rd_release && rd_bank_ready;

   always_comb begin
      word_w = pack_q;
      word_w[tap_q*KERNEL_WIDTH +: KERNEL_WIDTH] = s_weight_data;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ch_d        = ch_q;
      tap_d       = tap_q;
      pack_d      = pack_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      bank_full_d = bank_full_q;
      wr_fire     = 1'b0;
      case (state_q)
         IDLE: if (load_start && load_channels != '0) begin
            cnt_d   = load_channels;
            ch_d    = '0;
            tap_d   = '0;
            state_d = bank_full_q[wr_bank_q] ? WAIT : LOAD;
         end
         WAIT: if (!bank_full_q[wr_bank_q]) state_d = LOAD;
         LOAD: if (s_weight_valid) begin
            pack_d = word_w;
            if (tap_q == TAP_W'(TAPS-1)) begin
               tap_d   = '0;
               ch_d    = ch_q + 1'b1;
               wr_fire = 1'b1;
               if (ch_q == cnt_q - 1'b1) begin
                  state_d   = IDLE;
                  wr_bank_d = ~wr_bank_q;
               end
            end else begin
               tap_d = tap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A release and a commit never target the same bank, so both apply
      if (rel_fire) begin
         bank_full_d[rd_bank_q] = 1'b0;
         rd_bank_d              = ~rd_bank_q;
      end
      if (wr_fire && state_d == IDLE) bank_full_d[wr_bank_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ch_q        <= '0;
         tap_q       <= '0;
         pack_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         bank_full_q <= 2'b00;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ch_q        <= ch_d;
         tap_q       <= tap_d;
         pack_q      <= pack_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         bank_full_q <= bank_full_d;
         rd_valid_q  <= rd_fire;
         if (rd_fire) rd_data_q <= bank_mem[{rd_bank_q, rd_addr}];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_fire) bank_mem[{wr_bank_q, ch_q[ADDR_W-1:0]}] <= word_w;
   end

endmodule

// File: tb/tb_kernel_buffer_pingpong.sv
// Directed bench for kernel_buffer_pingpong: table-driven readbacks plus hand-written
// sequences for ping-pong, back-pressure, release/read overlap, reset abort and extremes.
module tb_kernel_buffer_pingpong;
   localparam int KW = 16, TAPS = 9, MAX_CH = 256, AW = 8, WW = KW * TAPS;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic [AW:0]   load_channels;
   logic          load_busy;
   logic [KW-1:0] s_weight_data;
   logic          s_weight_valid;
   logic          s_weight_ready;
   logic [1:0]    bank_full;
   logic          rd_bank_ready;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [WW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_release;

   kernel_buffer_pingpong dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_channels(load_channels),
      .load_busy(load_busy), .s_weight_data(s_weight_data), .s_weight_valid(s_weight_valid),
      .s_weight_ready(s_weight_ready), .bank_full(bank_full), .rd_bank_ready(rd_bank_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_release(rd_release)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            phase;
      string         nm;
      logic [AW-1:0] addr;
      int            base;
   } rd_vec_t;

   rd_vec_t vecs[9];
   int tests = 0;
   int failed = 0;

   function automatic logic [WW-1:0] kword(int base);
      logic [WW-1:0] w = '0;
      for (int k = 0; k < TAPS; k++) w[k*KW +: KW] = KW'(base + k);
      return w;
   endfunction

   task automatic chk(string nm, logic [WW-1:0] act, logic [WW-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(int n);
      load_start    = 1'b1;
      load_channels = (AW+1)'(n);
      tick();
      load_start    = 1'b0;
   endtask

   task automatic push(int base, int n);
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         s_weight_data  = KW'(base + i);
         s_weight_valid = 1'b1;
         while (!s_weight_ready && guard < 100) begin
            tick();
            guard++;
         end
         if (!s_weight_ready) begin
            chk("push_timeout", 0, 1);
            s_weight_valid = 1'b0;
            return;
         end
         tick();
      end
      s_weight_valid = 1'b0;
   endtask

   task automatic do_read(string nm, logic [AW-1:0] a, logic [WW-1:0] exp);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
      chk({nm, "_valid"}, WW'(rd_valid), 1);
      chk({nm, "_data"}, rd_data, exp);
   endtask

   task automatic run_reads(int phase);
      foreach (vecs[i])
         if (vecs[i].phase == phase) do_read(vecs[i].nm, vecs[i].addr, kword(vecs[i].base));
   endtask

   initial begin
      bit saw_ready;
      vecs[0] = '{0, "b0_a1", 8'd1, 10};
      vecs[1] = '{0, "b0_a0", 8'd0, 1};
      vecs[2] = '{1, "b1_a0", 8'd0, 19};
      vecs[3] = '{1, "b1_a3", 8'd3, 46};
      vecs[4] = '{1, "b1_a2", 8'd2, 37};
      vecs[5] = '{2, "rel_a0", 8'd0, 100};
      vecs[6] = '{3, "max_a255", 8'd255, 2295};
      vecs[7] = '{3, "max_a0", 8'd0, 0};
      vecs[8] = '{3, "max_a128", 8'd128, 1152};

      rst = 1'b1; load_start = 1'b0; load_channels = '0; s_weight_data = '0;
      s_weight_valid = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_busy", WW'(load_busy), 0);
      chk("rst_ready", WW'(s_weight_ready), 0);
      chk("rst_full", WW'(bank_full), 0);
      chk("rst_rdready", WW'(rd_bank_ready), 0);
      chk("rst_rdvalid", WW'(rd_valid), 0);
      chk("rst_rddata", rd_data, 0);

      // First load: 2 channels, weights 1..18 into bank0
      start_load(2);
      chk("l0_busy", WW'(load_busy), 1);
      chk("l0_ready", WW'(s_weight_ready), 1);
      push(1, 17);
      chk("l0_notfull", WW'(bank_full), 0);
      push(18, 1);
      chk("l0_full", WW'(bank_full), 2'b01);
      chk("l0_idle", WW'(load_busy), 0);
      run_reads(0);
      tick();
      chk("rdvalid_fall", WW'(rd_valid), 0);
      chk("rddata_hold", rd_data, kword(1));

      // Bank1 fills while bank0 keeps serving reads
      start_load(4);
      push(19, 9);
      do_read("pp_b0", 8'd1, kword(10));
      push(28, 27);
      chk("pp_full", WW'(bank_full), 2'b11);

      // Both full: third load must stall until a release
      start_load(1);
      s_weight_data  = 16'd999;
      s_weight_valid = 1'b1;
      saw_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (s_weight_ready) saw_ready = 1'b1;
         tick();
      end
      chk("bp_stall", WW'(saw_ready), 0);
      chk("bp_busy", WW'(load_busy), 1);
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      chk("rel_full", WW'(bank_full), 2'b10);
      chk("rel_rdready", WW'(rd_bank_ready), 1);
      chk("bp_ready_e1", WW'(s_weight_ready), 0);
      tick();
      chk("bp_ready_e2", WW'(s_weight_ready), 1);
      push(200, 9);
      chk("bp_full", WW'(bank_full), 2'b11);
      run_reads(1);

      // Release bank1, then read+release bank0 in the same cycle
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      chk("rel2_full", WW'(bank_full), 2'b01);
      rd_en = 1'b1; rd_addr = 8'd0; rd_release = 1'b1;
      tick();
      rd_en = 1'b0; rd_release = 1'b0;
      chk("same_valid", WW'(rd_valid), 1);
      chk("same_data", rd_data, kword(200));
      chk("same_full", WW'(bank_full), 2'b00);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("ign_valid", WW'(rd_valid), 0);
      chk("ign_hold", rd_data, kword(200));

      // Reset partway through a load
      start_load(1);
      push(50, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_full", WW'(bank_full), 0);
      chk("abort_busy", WW'(load_busy), 0);
      chk("abort_ready", WW'(s_weight_ready), 0);
      start_load(1);
      push(100, 9);
      chk("reload_full", WW'(bank_full), 2'b01);
      run_reads(2);

      // Zero channel count is ignored
      start_load(0);
      chk("zero_busy", WW'(load_busy), 0);
      chk("zero_ready", WW'(s_weight_ready), 0);
      chk("zero_full", WW'(bank_full), 2'b01);

      // Full-depth load into bank1
      start_load(MAX_CH);
      push(0, MAX_CH*TAPS - 1);
      chk("max_notfull", WW'(bank_full), 2'b01);
      push(MAX_CH*TAPS - 1, 1);
      chk("max_full", WW'(bank_full), 2'b11);
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      run_reads(3);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
